// File: rtl/gem_frame_packer.sv
// GEM trigger-link frame builder: packs one cluster payload per bunch crossing into
// NWORDS 32-bit GTX words, closing each frame with a K-code separator byte.
module gem_frame_packer #(
  parameter int NWORDS       = 2,
  parameter int DATA_W       = 56,
  parameter int SEP_REPEAT   = 2,
  parameter int COMMA_CYCLES = 16,
  parameter int LT_BITS      = 8
) (
  input  logic              TRG_CLK80,
  input  logic              TRG_RST,
  input  logic [DATA_W-1:0] GEM_DATA,
  input  logic              GEM_OVERFLOW,
  input  logic              ENA_TEST_PAT,
  input  logic              INJ_ERR,
  output logic              DATA_REQ,
  output logic [31:0]       TX_DATA,
  output logic [3:0]        TX_ISK,
  output logic              FRAME_START,
  output logic [7:0]        GEM_FRAME,
  output logic              LTNCY_TRIG,
  output logic              TX_SYNCED,
  output logic              DBG_STATE
);

  localparam int FRAME_W = 32 * NWORDS;
  localparam int WC_W    = 2;
  localparam int REP_W   = 4;
  localparam int CC_W    = 8;

  localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(NWORDS - 1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(SEP_REPEAT - 1);
  localparam logic [CC_W-1:0]  COMMA_LAST = CC_W'(COMMA_CYCLES - 1);
  localparam logic [31:0]      COMMA_WORD = 32'h50BC50BC;
  localparam logic [3:0]       COMMA_ISK  = 4'b0101;
  localparam logic [7:0]       SEP_OVF    = 8'hFC;

  typedef enum logic {
    ST_COMMA = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CC_W-1:0]    ccnt_q, ccnt_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [1:0]         sep_idx_q, sep_idx_d;
  logic [LT_BITS-1:0] lt_cnt_q, lt_cnt_d;
  logic [30:0]        prbs_q, prbs_d;
  logic               inj_prev_q, inj_prev_d;
  logic               inj_pend_q, inj_pend_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic [3:0]         tx_isk_q, tx_isk_d;
  logic               frame_start_q, frame_start_d;
  logic [7:0]         gem_frame_q, gem_frame_d;
  logic               ltncy_q, ltncy_d;
  logic               synced_q, synced_d;

  logic               inj_edge;
  logic [DATA_W-1:0]  prbs_payload;
  logic [DATA_W-1:0]  payload;
  logic [7:0]         sep_base;
  logic [7:0]         sep;
  logic [31:0]        word_sel;

  assign DATA_REQ    = (state_q == ST_RUN) && (wcnt_q == '0);
  assign TX_DATA     = tx_data_q;
  assign TX_ISK      = tx_isk_q;
  assign FRAME_START = frame_start_q;
  assign GEM_FRAME   = gem_frame_q;
  assign LTNCY_TRIG  = ltncy_q;
  assign TX_SYNCED   = synced_q;
  assign DBG_STATE   = state_q;

  assign inj_edge = INJ_ERR & ~inj_prev_q;

  // The 31-bit PRBS state is tiled upward from bit 0 to fill the payload width.
  always_comb begin
    prbs_payload = '0;
    for (int i = 0; i < DATA_W; i++) begin
      prbs_payload[i] = prbs_q[i % 31];
    end
  end

  always_comb begin
    sep_base = 8'hBC;
    case (sep_idx_q)
      2'd0:    sep_base = 8'hBC;
      2'd1:    sep_base = 8'hF7;
      2'd2:    sep_base = 8'hFB;
      default: sep_base = 8'hFD;
    endcase
  end

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (wcnt_q == WC_W'(k)) begin
        word_sel = frame_q[FRAME_W-1-32*k -: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ccnt_d        = ccnt_q;
    wcnt_d        = wcnt_q;
    rep_d         = rep_q;
    sep_idx_d     = sep_idx_q;
    lt_cnt_d      = lt_cnt_q;
    prbs_d        = prbs_q;
    inj_prev_d    = INJ_ERR;
    inj_pend_d    = inj_pend_q | inj_edge;
    frame_d       = frame_q;
    tx_data_d     = COMMA_WORD;
    tx_isk_d      = COMMA_ISK;
    frame_start_d = 1'b0;
    gem_frame_d   = gem_frame_q;
    ltncy_d       = 1'b0;
    synced_d      = synced_q;
    payload       = '0;
    sep           = sep_base;

    case (state_q)
      ST_COMMA: begin
        ccnt_d = ccnt_q + CC_W'(1);
        if (ccnt_q == COMMA_LAST) begin
          state_d  = ST_RUN;
          synced_d = 1'b1;
        end
      end

      default: begin
        wcnt_d = (wcnt_q == LAST_WORD) ? '0 : wcnt_q + WC_W'(1);
        if (DATA_REQ) begin
          payload = ENA_TEST_PAT ? prbs_payload : GEM_DATA;
          // A pending error flips the MSB; an edge seen this same cycle waits a frame.
          if (inj_pend_q) begin
            payload[DATA_W-1] = ~payload[DATA_W-1];
          end
          inj_pend_d    = inj_edge;
          sep           = GEM_OVERFLOW ? SEP_OVF : sep_base;
          frame_d       = {payload, sep};
          tx_data_d     = frame_d[FRAME_W-1 -: 32];
          tx_isk_d      = 4'b0000;
          frame_start_d = 1'b1;
          gem_frame_d   = sep;
          ltncy_d       = (lt_cnt_q == '0);
          lt_cnt_d      = lt_cnt_q + LT_BITS'(1);
          prbs_d        = {prbs_q[29:0], prbs_q[30] ^ prbs_q[27]};
          // Overflow frames still consume a slot of the separator sequence.
          if (rep_q == REP_LAST) begin
            rep_d     = '0;
            sep_idx_d = sep_idx_q + 2'd1;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end else begin
          tx_data_d = word_sel;
          tx_isk_d  = (wcnt_q == LAST_WORD) ? 4'b0001 : 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      state_q       <= ST_COMMA;
      ccnt_q        <= '0;
      wcnt_q        <= '0;
      rep_q         <= '0;
      sep_idx_q     <= '0;
      lt_cnt_q      <= '0;
      prbs_q        <= '1;
      inj_prev_q    <= 1'b0;
      inj_pend_q    <= 1'b0;
      frame_q       <= '0;
      tx_data_q     <= COMMA_WORD;
      tx_isk_q      <= COMMA_ISK;
      frame_start_q <= 1'b0;
      gem_frame_q   <= 8'hBC;
      ltncy_q       <= 1'b0;
      synced_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ccnt_q        <= ccnt_d;
      wcnt_q        <= wcnt_d;
      rep_q         <= rep_d;
      sep_idx_q     <= sep_idx_d;
      lt_cnt_q      <= lt_cnt_d;
      prbs_q        <= prbs_d;
      inj_prev_q    <= inj_prev_d;
      inj_pend_q    <= inj_pend_d;
      frame_q       <= frame_d;
      tx_data_q     <= tx_data_d;
      tx_isk_q      <= tx_isk_d;
      frame_start_q <= frame_start_d;
      gem_frame_q   <= gem_frame_d;
      ltncy_q       <= ltncy_d;
      synced_q      <= synced_d;
    end
  end

endmodule
